clk_div_prog: RTL

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog_if.sv | 33 +++
 rtl/clk_div_prog.sv | 110 +++++++++++
 2 files changed

// File: rtl/clk_div_prog_if.sv
// Control and output bundle for clk_div_prog. The testbench drives it through the master modport.
// The o_tick member exists only when CLKDIV_TICK_EN is defined.
interface clk_div_prog_if #(
    parameter int RATIO_WIDTH = 8
);
    logic                   i_clk_en;
    logic [RATIO_WIDTH-1:0] i_div_ratio;
    logic                   o_div_clk;
    logic [RATIO_WIDTH-1:0] o_ratio_active;
`ifdef CLKDIV_TICK_EN
    logic                   o_tick;
`endif

    modport master (
        output i_clk_en,
        output i_div_ratio,
        input  o_div_clk,
        input  o_ratio_active
`ifdef CLKDIV_TICK_EN
       ,input  o_tick
`endif
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
        output o_div_clk,
        output o_ratio_active
`ifdef CLKDIV_TICK_EN
       ,output o_tick
`endif
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider with IDLE/BYPASS/DIVIDE states; ratio changes apply only at period boundaries.
// Optional feature macro: CLKDIV_TICK_EN adds the registered o_tick period-start strobe.
module clk_div_prog #(
    parameter int RATIO_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    clk_div_prog_if.slave      bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYPASS = 2'd1,
        ST_DIVIDE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [RATIO_WIDTH-1:0] r_count;
    logic [RATIO_WIDTH-1:0] r_ratio;
    logic                   r_div;

    logic [RATIO_WIDTH-1:0] w_ratio_in;
    logic [RATIO_WIDTH-1:0] w_count_inc;
    logic [RATIO_WIDTH-1:0] w_half;
    logic                   w_new_divides;
    logic                   w_last;

    assign w_ratio_in    = bus.i_div_ratio;
    assign w_new_divides = (w_ratio_in > RATIO_WIDTH'(1));
    // The counter never exceeds r_ratio-1, so the increment cannot wrap even at the maximum ratio.
    assign w_count_inc   = r_count + RATIO_WIDTH'(1);
    assign w_half        = r_ratio >> 1;
    assign w_last        = (r_count == r_ratio - RATIO_WIDTH'(1));

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_ratio <= '0;
            r_div   <= 1'b0;
        end else if (!bus.i_clk_en) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_div   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ratio <= w_ratio_in;
                    r_count <= '0;
                    if (w_new_divides) begin
                        r_state <= ST_DIVIDE;
                        r_div   <= 1'b1;
                    end else begin
                        r_state <= ST_BYPASS;
                        r_div   <= 1'b0;
                    end
                end
                ST_BYPASS: begin
                    r_count <= '0;
                    if (w_new_divides) begin
                        r_state <= ST_DIVIDE;
                        r_ratio <= w_ratio_in;
                        r_div   <= 1'b1;
                    end else begin
                        r_div   <= 1'b0;
                    end
                end
                ST_DIVIDE: begin
                    if (w_last) begin
                        r_count <= '0;
                        r_ratio <= w_ratio_in;
                        if (w_new_divides) begin
                            r_div   <= 1'b1;
                        end else begin
                            r_state <= ST_BYPASS;
                            r_div   <= 1'b0;
                        end
                    end else begin
                        r_count <= w_count_inc;
                        r_div   <= (w_count_inc < w_half);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                    r_div   <= 1'b0;
                end
            endcase
        end
    end

    // Bypass passes the input clock straight through; every other state shows the registered phase.
    assign bus.o_div_clk      = (r_state == ST_BYPASS) ? i_clk : r_div;
    assign bus.o_ratio_active = r_ratio;

`ifdef CLKDIV_TICK_EN
    // Any enabled edge outside DIVIDE lands in BYPASS or starts a period; inside DIVIDE only the boundary does.
    logic r_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= bus.i_clk_en && ((r_state != ST_DIVIDE) || w_last);
        end
    end

    assign bus.o_tick = r_tick;
`endif
endmodule
